clarvi_mem_arbiter: RTL and testbench

Shares one 16-bit Avalon-MM memory slave between the clarvi data port (main) and the instruction port (instr). This allows a single-port on-chip RAM to serve both ports.
- Grants per cycle by fixed priority to main, with an anti-starvation counter for instr.
- Locks the grant while the slave asserts waitrequest.
- Routes each read response back to its issuer via an in-order tag FIFO.
- Sits between the clarvi_avalon core and the memory.

---
 rtl/clarvi_arb_pkg.sv | 20 ++
 rtl/clarvi_arb_tag_fifo.sv | 69 ++++++
 rtl/clarvi_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_clarvi_mem_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clarvi_arb_pkg.sv
// Purpose: shared types and constants for the clarvi memory arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package clarvi_arb_pkg;

  // Issuer of a transfer; also the payload of the response-routing FIFO.
  typedef enum logic {
    SRC_MAIN  = 1'b0,
    SRC_INSTR = 1'b1
  } src_t;

  // Width of the anti-starvation counter.
  localparam int STARVE_W = 8;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int fifo_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/clarvi_arb_tag_fifo.sv
// Purpose: in-order FIFO of source tags, one per outstanding memory read.
// Latency: push visible at dout the cycle after; dout is the head, read combinationally.
// Backpressure: full/empty flags; push at full only lands when a pop happens the same cycle.
//
// Ports: clock/reset (sync, active-high), push/din write side,
//        pop/dout read side, full/empty status.
module clarvi_arb_tag_fifo
  import clarvi_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  src_t din,
  output src_t dout,
  output logic full,
  output logic empty
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  src_t          mem_q [DEPTH];
  src_t          mem_d [DEPTH];
  logic          do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    dout     = mem_q[rd_ptr_q];
    // Pop at empty is ignored; push at full needs a same-cycle pop.
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/clarvi_mem_arbiter.sv
// Purpose: shares one 16-bit Avalon-MM slave between clarvi's data (main) and instruction ports.
// Latency: zero added cycles on requests (combinational grant); responses routed the same cycle.
// Backpressure: loser and blocked winner see waitrequest=1; reads stall while the tag FIFO is full.
//
// Ports: clock/reset (sync, active-high); avs_main_* data-port slave;
//        avs_instr_* fetch-port slave (read-only); avm_mem_* master to memory;
//        err_spurious sticky flag for a response with no outstanding read.
module clarvi_mem_arbiter
  import clarvi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 14,
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] avs_main_address,
  input  logic [1:0]            avs_main_byteenable,
  input  logic                  avs_main_read,
  input  logic                  avs_main_write,
  input  logic [15:0]           avs_main_writedata,
  output logic [15:0]           avs_main_readdata,
  output logic                  avs_main_waitrequest,
  output logic                  avs_main_readdatavalid,
  input  logic [ADDR_WIDTH-1:0] avs_instr_address,
  input  logic                  avs_instr_read,
  output logic [15:0]           avs_instr_readdata,
  output logic                  avs_instr_waitrequest,
  output logic                  avs_instr_readdatavalid,
  output logic [ADDR_WIDTH-1:0] avm_mem_address,
  output logic [1:0]            avm_mem_byteenable,
  output logic                  avm_mem_read,
  output logic                  avm_mem_write,
  output logic [15:0]           avm_mem_writedata,
  input  logic [15:0]           avm_mem_readdata,
  input  logic                  avm_mem_waitrequest,
  input  logic                  avm_mem_readdatavalid,
  output logic                  err_spurious
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic                lock_q, lock_d;
  src_t                lock_id_q, lock_id_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                err_q, err_d;

  logic req_m, req_i;
  logic gnt_vld;
  src_t gnt_id;
  logic win_read, win_write, win_active;
  logic block, issue, accept;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  src_t fifo_dout;

  clarvi_arb_tag_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (gnt_id),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Arbitration, bus mux and handshake.
  always_comb begin
    req_m   = avs_main_read | avs_main_write;
    req_i   = avs_instr_read;
    gnt_vld = 1'b0;
    gnt_id  = SRC_MAIN;
    if (lock_q) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id_q;
    end else if (req_m && req_i) begin
      gnt_vld = 1'b1;
      gnt_id  = (starve_cnt_q == LIMIT) ? SRC_INSTR : SRC_MAIN;
    end else if (req_m) begin
      gnt_vld = 1'b1;
      gnt_id  = SRC_MAIN;
    end else if (req_i) begin
      gnt_vld = 1'b1;
      gnt_id  = SRC_INSTR;
    end

    win_read   = gnt_vld & ((gnt_id == SRC_MAIN) ? avs_main_read : avs_instr_read);
    win_write  = gnt_vld & (gnt_id == SRC_MAIN) & avs_main_write;
    win_active = win_read | win_write;

    // A read with nowhere to park its tag must not reach the memory, or the
    // slave would accept it while the requester is told to wait.
    block  = win_read & fifo_full & ~avm_mem_readdatavalid;
    issue  = ~reset & ~block & win_active;
    accept = issue & ~avm_mem_waitrequest;

    avm_mem_address    = (gnt_id == SRC_INSTR) ? avs_instr_address : avs_main_address;
    avm_mem_byteenable = (gnt_id == SRC_INSTR) ? 2'b11 : avs_main_byteenable;
    avm_mem_read       = issue & win_read;
    avm_mem_write      = issue & win_write;
    avm_mem_writedata  = avs_main_writedata;

    if (reset) begin
      avs_main_waitrequest  = 1'b1;
      avs_instr_waitrequest = 1'b1;
    end else begin
      avs_main_waitrequest  = (gnt_vld && gnt_id == SRC_MAIN)
                              ? (avm_mem_waitrequest | block) : req_m;
      avs_instr_waitrequest = (gnt_vld && gnt_id == SRC_INSTR)
                              ? (avm_mem_waitrequest | block) : req_i;
    end

    fifo_push = accept & win_read;
    fifo_pop  = ~reset & avm_mem_readdatavalid & ~fifo_empty;

    avs_main_readdata       = avm_mem_readdata;
    avs_instr_readdata      = avm_mem_readdata;
    avs_main_readdatavalid  = fifo_pop & (fifo_dout == SRC_MAIN);
    avs_instr_readdatavalid = fifo_pop & (fifo_dout == SRC_INSTR);
  end

  // Next-state for lock, starvation counter and error flag.
  always_comb begin
    // Keyed on an active request so a requester that (illegally) drops
    // mid-stall cannot leave the grant locked forever.
    lock_d    = win_active & ~accept;
    lock_id_d = lock_d ? gnt_id : lock_id_q;

    starve_cnt_d = starve_cnt_q;
    if (!req_i || (accept && gnt_id == SRC_INSTR)) begin
      starve_cnt_d = '0;
    end else if (win_active && gnt_id == SRC_MAIN && starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end

    err_d = err_q | (avm_mem_readdatavalid & fifo_empty);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q       <= 1'b0;
      lock_id_q    <= SRC_MAIN;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
    end
  end

  assign err_spurious = err_q;

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// Purpose: directed self-checking bench for clarvi_mem_arbiter (default parameters).
// Latency: inputs driven 2 time units after posedge, outputs sampled 1 unit later.
// Backpressure: memory waitrequest/readdatavalid driven directly by the stimulus.
module tb_clarvi_mem_arbiter;

  localparam int AW = 14;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] avs_main_address;
  logic [1:0]    avs_main_byteenable;
  logic          avs_main_read;
  logic          avs_main_write;
  logic [15:0]   avs_main_writedata;
  logic [15:0]   avs_main_readdata;
  logic          avs_main_waitrequest;
  logic          avs_main_readdatavalid;
  logic [AW-1:0] avs_instr_address;
  logic          avs_instr_read;
  logic [15:0]   avs_instr_readdata;
  logic          avs_instr_waitrequest;
  logic          avs_instr_readdatavalid;
  logic [AW-1:0] avm_mem_address;
  logic [1:0]    avm_mem_byteenable;
  logic          avm_mem_read;
  logic          avm_mem_write;
  logic [15:0]   avm_mem_writedata;
  logic [15:0]   avm_mem_readdata;
  logic          avm_mem_waitrequest;
  logic          avm_mem_readdatavalid;
  logic          err_spurious;

  int checks = 0;
  int errors = 0;

  clarvi_mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .MAX_PENDING  (4),
    .STARVE_LIMIT (4)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .avs_main_address        (avs_main_address),
    .avs_main_byteenable     (avs_main_byteenable),
    .avs_main_read           (avs_main_read),
    .avs_main_write          (avs_main_write),
    .avs_main_writedata      (avs_main_writedata),
    .avs_main_readdata       (avs_main_readdata),
    .avs_main_waitrequest    (avs_main_waitrequest),
    .avs_main_readdatavalid  (avs_main_readdatavalid),
    .avs_instr_address       (avs_instr_address),
    .avs_instr_read          (avs_instr_read),
    .avs_instr_readdata      (avs_instr_readdata),
    .avs_instr_waitrequest   (avs_instr_waitrequest),
    .avs_instr_readdatavalid (avs_instr_readdatavalid),
    .avm_mem_address         (avm_mem_address),
    .avm_mem_byteenable      (avm_mem_byteenable),
    .avm_mem_read            (avm_mem_read),
    .avm_mem_write           (avm_mem_write),
    .avm_mem_writedata       (avm_mem_writedata),
    .avm_mem_readdata        (avm_mem_readdata),
    .avm_mem_waitrequest     (avm_mem_waitrequest),
    .avm_mem_readdatavalid   (avm_mem_readdatavalid),
    .err_spurious            (err_spurious)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    avs_main_address      = '0;
    avs_main_byteenable   = 2'b11;
    avs_main_read         = 1'b0;
    avs_main_write        = 1'b0;
    avs_main_writedata    = '0;
    avs_instr_address     = '0;
    avs_instr_read        = 1'b0;
    avm_mem_readdata      = '0;
    avm_mem_waitrequest   = 1'b0;
    avm_mem_readdatavalid = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    idle_inputs();
    reset = 1'b1;
    avs_main_read = 1'b1;
    avs_instr_read = 1'b1;
    avm_mem_readdatavalid = 1'b1;
    tick();
    tick();
    #1;
    obs = {avm_mem_read, avm_mem_write, avs_main_waitrequest, avs_instr_waitrequest,
           avs_main_readdatavalid, avs_instr_readdatavalid};
    checks++;
    if (obs !== 6'b001100) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 001100", obs);
    end
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", err_spurious);
    end
    idle_inputs();
    reset = 1'b0;
    tick();
    #1;
    obs = {avm_mem_read, avm_mem_write, avs_main_waitrequest, avs_instr_waitrequest,
           avs_main_readdatavalid, avs_instr_readdatavalid};
    checks++;
    if (obs !== 6'b000000 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b err=%b expected 000000 err=0", obs, err_spurious);
    end
  endtask

  task automatic test_lone_fetch();
    avs_instr_read = 1'b1;
    avs_instr_address = 14'h010;
    #1;
    checks++;
    if ({avm_mem_read, avm_mem_write, avs_instr_waitrequest, avm_mem_address, avm_mem_byteenable}
        !== {1'b1, 1'b0, 1'b0, 14'h010, 2'b11}) begin
      errors++;
      $display("FAIL fetch_issue: rd=%b wr=%b iwait=%b addr=%h be=%b expected 1 0 0 010 11",
               avm_mem_read, avm_mem_write, avs_instr_waitrequest, avm_mem_address, avm_mem_byteenable);
    end
    tick();
    avs_instr_read = 1'b0;
    avm_mem_readdatavalid = 1'b1;
    avm_mem_readdata = 16'hBEEF;
    #1;
    checks++;
    if ({avs_main_readdatavalid, avs_instr_readdatavalid, avs_instr_readdata} !== {2'b01, 16'hBEEF}) begin
      errors++;
      $display("FAIL fetch_response: mrdv=%b irdv=%b data=%h expected 0 1 beef",
               avs_main_readdatavalid, avs_instr_readdatavalid, avs_instr_readdata);
    end
    tick();
    avm_mem_readdatavalid = 1'b0;
  endtask

  task automatic test_contention();
    avs_main_write = 1'b1;
    avs_main_address = 14'h020;
    avs_main_writedata = 16'h1234;
    avs_main_byteenable = 2'b01;
    avs_instr_read = 1'b1;
    avs_instr_address = 14'h030;
    #1;
    checks++;
    if ({avm_mem_read, avm_mem_write, avs_main_waitrequest, avs_instr_waitrequest} !== 4'b0101) begin
      errors++;
      $display("FAIL contention_first: rd/wr/mw/iw got %b expected 0101",
               {avm_mem_read, avm_mem_write, avs_main_waitrequest, avs_instr_waitrequest});
    end
    checks++;
    if ({avm_mem_address, avm_mem_byteenable, avm_mem_writedata} !== {14'h020, 2'b01, 16'h1234}) begin
      errors++;
      $display("FAIL contention_write_bus: addr=%h be=%b wd=%h expected 020 01 1234",
               avm_mem_address, avm_mem_byteenable, avm_mem_writedata);
    end
    tick();
    avs_main_write = 1'b0;
    #1;
    checks++;
    if ({avm_mem_read, avm_mem_write, avs_instr_waitrequest, avm_mem_address} !== {3'b100, 14'h030}) begin
      errors++;
      $display("FAIL contention_second: rd=%b wr=%b iw=%b addr=%h expected 1 0 0 030",
               avm_mem_read, avm_mem_write, avs_instr_waitrequest, avm_mem_address);
    end
    tick();
    avs_instr_read = 1'b0;
    avm_mem_readdatavalid = 1'b1;
    avm_mem_readdata = 16'h5A5A;
    #1;
    checks++;
    if ({avs_main_readdatavalid, avs_instr_readdatavalid} !== 2'b01) begin
      errors++;
      $display("FAIL contention_response: got %b expected 01",
               {avs_main_readdatavalid, avs_instr_readdatavalid});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic [3:0] exp_v;
    avs_main_write = 1'b1;
    avs_instr_read = 1'b1;
    avs_instr_address = 14'h077;
    for (int c = 0; c < 10; c++) begin
      avs_main_address = 14'h200 + 14'(c);
      #1;
      // Limit 4: main wins four contended cycles, then instr is forced through.
      exp_v = (c == 4 || c == 9) ? 4'b1010 : 4'b0101;
      checks++;
      if ({avm_mem_read, avm_mem_write, avs_main_waitrequest, avs_instr_waitrequest} !== exp_v) begin
        errors++;
        $display("FAIL starve_cycle%0d: rd/wr/mw/iw got %b expected %b", c,
                 {avm_mem_read, avm_mem_write, avs_main_waitrequest, avs_instr_waitrequest}, exp_v);
      end
      tick();
    end
    avs_main_write = 1'b0;
    avs_instr_read = 1'b0;
    avm_mem_readdatavalid = 1'b1;
    for (int r = 0; r < 2; r++) begin
      avm_mem_readdata = 16'h0100 + 16'(r);
      #1;
      checks++;
      if ({avs_main_readdatavalid, avs_instr_readdatavalid} !== 2'b01) begin
        errors++;
        $display("FAIL starve_response%0d: got %b expected 01", r,
                 {avs_main_readdatavalid, avs_instr_readdatavalid});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_wait_lock();
    logic [1:0] exp_rdv [3];
    exp_rdv[0] = 2'b10;
    exp_rdv[1] = 2'b01;
    exp_rdv[2] = 2'b10;
    avs_main_read = 1'b1;
    avs_main_address = 14'h040;
    avs_instr_read = 1'b1;
    avs_instr_address = 14'h050;
    avm_mem_waitrequest = 1'b1;
    // Five stalled cycles: the starve count hits its limit mid-stall, so only
    // the lock keeps the grant on main.
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({avm_mem_read, avm_mem_write, avs_main_waitrequest, avs_instr_waitrequest, avm_mem_address}
          !== {4'b1011, 14'h040}) begin
        errors++;
        $display("FAIL lock_stall%0d: rd/wr/mw/iw=%b addr=%h expected 1011 040", c,
                 {avm_mem_read, avm_mem_write, avs_main_waitrequest, avs_instr_waitrequest}, avm_mem_address);
      end
      tick();
    end
    avm_mem_waitrequest = 1'b0;
    #1;
    checks++;
    if ({avm_mem_read, avs_main_waitrequest, avs_instr_waitrequest, avm_mem_address} !== {3'b101, 14'h040}) begin
      errors++;
      $display("FAIL lock_accept: rd=%b mw=%b iw=%b addr=%h expected 1 0 1 040",
               avm_mem_read, avs_main_waitrequest, avs_instr_waitrequest, avm_mem_address);
    end
    tick();
    avs_main_address = 14'h044;
    #1;
    checks++;
    if ({avm_mem_read, avs_main_waitrequest, avs_instr_waitrequest, avm_mem_address} !== {3'b110, 14'h050}) begin
      errors++;
      $display("FAIL lock_instr_after: rd=%b mw=%b iw=%b addr=%h expected 1 1 0 050",
               avm_mem_read, avs_main_waitrequest, avs_instr_waitrequest, avm_mem_address);
    end
    tick();
    avs_instr_read = 1'b0;
    #1;
    checks++;
    if ({avm_mem_read, avs_main_waitrequest, avm_mem_address} !== {2'b10, 14'h044}) begin
      errors++;
      $display("FAIL lock_main_resume: rd=%b mw=%b addr=%h expected 1 0 044",
               avm_mem_read, avs_main_waitrequest, avm_mem_address);
    end
    tick();
    avs_main_read = 1'b0;
    avm_mem_readdatavalid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      avm_mem_readdata = 16'h1111 * 16'(r + 1);
      #1;
      checks++;
      if ({avs_main_readdatavalid, avs_instr_readdatavalid} !== exp_rdv[r]) begin
        errors++;
        $display("FAIL lock_response%0d: got %b expected %b", r,
                 {avs_main_readdatavalid, avs_instr_readdatavalid}, exp_rdv[r]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    logic       rdv_pat [5];
    logic [1:0] exp_rdv [5];
    rdv_pat[0] = 1'b1; exp_rdv[0] = 2'b01;
    rdv_pat[1] = 1'b1; exp_rdv[1] = 2'b10;
    rdv_pat[2] = 1'b1; exp_rdv[2] = 2'b01;
    rdv_pat[3] = 1'b0; exp_rdv[3] = 2'b00;
    rdv_pat[4] = 1'b1; exp_rdv[4] = 2'b10;
    // Four reads alternating main/instr, each accepted at once.
    for (int c = 0; c < 4; c++) begin
      avs_main_read  = (c % 2 == 0);
      avs_instr_read = (c % 2 == 1);
      avs_main_address  = 14'h100 + 14'(c);
      avs_instr_address = 14'h100 + 14'(c);
      #1;
      checks++;
      if ({avm_mem_read, avs_main_waitrequest, avs_instr_waitrequest, avm_mem_address}
          !== {3'b100, 14'h100 + 14'(c)}) begin
        errors++;
        $display("FAIL fill%0d: rd=%b mw=%b iw=%b addr=%h expected 1 0 0 %h", c,
                 avm_mem_read, avs_main_waitrequest, avs_instr_waitrequest, avm_mem_address, 14'h100 + 14'(c));
      end
      tick();
    end
    avs_instr_read = 1'b0;
    avs_main_read = 1'b1;
    avs_main_address = 14'h104;
    #1;
    checks++;
    if ({avm_mem_read, avm_mem_write, avs_main_waitrequest} !== 3'b001) begin
      errors++;
      $display("FAIL full_block: rd/wr/mw got %b expected 001",
               {avm_mem_read, avm_mem_write, avs_main_waitrequest});
    end
    tick();
    avm_mem_readdatavalid = 1'b1;
    avm_mem_readdata = 16'hA000;
    #1;
    checks++;
    if ({avm_mem_read, avs_main_waitrequest, avm_mem_address, avs_main_readdatavalid, avs_instr_readdatavalid}
        !== {2'b10, 14'h104, 2'b10}) begin
      errors++;
      $display("FAIL full_pop_push: rd=%b mw=%b addr=%h rdv=%b expected 1 0 104 10",
               avm_mem_read, avs_main_waitrequest, avm_mem_address,
               {avs_main_readdatavalid, avs_instr_readdatavalid});
    end
    tick();
    avs_main_read = 1'b0;
    for (int r = 0; r < 5; r++) begin
      avm_mem_readdatavalid = rdv_pat[r];
      avm_mem_readdata = 16'hA001 + 16'(r);
      #1;
      checks++;
      if ({avs_main_readdatavalid, avs_instr_readdatavalid} !== exp_rdv[r]) begin
        errors++;
        $display("FAIL order_response%0d: got %b expected %b", r,
                 {avs_main_readdatavalid, avs_instr_readdatavalid}, exp_rdv[r]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    avm_mem_readdatavalid = 1'b1;
    avm_mem_readdata = 16'hDEAD;
    #1;
    checks++;
    if ({avs_main_readdatavalid, avs_instr_readdatavalid, err_spurious} !== 3'b000) begin
      errors++;
      $display("FAIL spurious_drop: rdv/err got %b expected 000",
               {avs_main_readdatavalid, avs_instr_readdatavalid, err_spurious});
    end
    tick();
    avm_mem_readdatavalid = 1'b0;
    tick();
    #1;
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++;
      $display("FAIL spurious_sticky: got %b expected 1", err_spurious);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL spurious_clear: got %b expected 0", err_spurious);
    end
    // Read accepted, then reset before its response returns.
    tick();
    avs_main_read = 1'b1;
    avs_main_address = 14'h300;
    #1;
    checks++;
    if (avm_mem_read !== 1'b1) begin
      errors++;
      $display("FAIL midreset_issue: rd=%b expected 1", avm_mem_read);
    end
    tick();
    avs_main_read = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    avm_mem_readdatavalid = 1'b1;
    #1;
    checks++;
    if ({avs_main_readdatavalid, avs_instr_readdatavalid} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_drop: got %b expected 00",
               {avs_main_readdatavalid, avs_instr_readdatavalid});
    end
    tick();
    avm_mem_readdatavalid = 1'b0;
    #1;
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++;
      $display("FAIL midreset_err: got %b expected 1", err_spurious);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_lone_fetch();
    test_contention();
    test_starvation();
    test_wait_lock();
    test_fifo_full();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
